mult_div_sequencer: RTL and testbench

Multi-cycle HI/LO unit for the MIPS core. It executes MULT, MULTU, DIV and DIVU sequentially instead of in one combinational cycle, owns the architectural HI and LO registers, and services MTHI/MTLO writes. It sits beside the ALU in the execute stage. It raises busy so hazard logic stalls MFHI/MFLO and any new HI/LO operation until the result is committed.

---
 rtl/mult_div_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_mult_div_sequencer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_sequencer.sv
// mult_div_sequencer: multi-cycle HI/LO unit for the MIPS execute stage.
// Runs MULT/MULTU over MULT_LATENCY cycles and DIV/DIVU as a 32-step
// restoring divider. Owns the HI/LO registers and services MTHI/MTLO.
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   start, op           request strobe and MIPS funct code (sampled when !busy)
//   operand_a/b         rs / rt values
//   busy                operation in flight (hazard logic stalls on it)
//   done, div_by_zero   one-cycle completion pulse; zero-divisor flag with done
//   hi, lo              architectural HI and LO registers
module mult_div_sequencer #(
  parameter int MULT_LATENCY = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  op,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  localparam logic [5:0] OP_MTHI  = 6'b010001;
  localparam logic [5:0] OP_MTLO  = 6'b010011;
  localparam logic [5:0] OP_MULT  = 6'b011000;
  localparam logic [5:0] OP_MULTU = 6'b011001;
  localparam logic [5:0] OP_DIV   = 6'b011010;
  localparam logic [5:0] OP_DIVU  = 6'b011011;

  // FIX is the division done cycle; it accepts new work just like IDLE.
  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] opa_q, opa_d;   // multiplicand
  logic [31:0] opb_q, opb_d;   // multiplier / divisor magnitude
  logic [31:0] quo_q, quo_d;   // dividend shifting out, quotient shifting in
  logic [31:0] rem_q, rem_d;
  logic        msgn_q, msgn_d;  // signed multiply
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;
  logic        done_q, done_d;
  logic        dbz_q, dbz_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;

  logic [32:0] rem_sh, diff;
  logic [31:0] rem_n, quo_n;
  logic        a_neg, b_neg;

  // Sign/zero-extend to 64 bits; the low 64 bits of the product are correct
  // for both signed and unsigned operands.
  function automatic logic [63:0] mul64(input logic [31:0] a, input logic [31:0] b,
                                        input logic sgn);
    logic [63:0] ea, eb;
    ea = {{32{sgn & a[31]}}, a};
    eb = {{32{sgn & b[31]}}, b};
    return ea * eb;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    msgn_d  = msgn_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    done_d  = 1'b0;
    dbz_d   = 1'b0;
    hi_d    = hi_q;
    lo_d    = lo_q;
    a_neg   = 1'b0;
    b_neg   = 1'b0;

    // One restoring step: the 33-bit compare keeps |0x80000000| safe.
    rem_sh = {rem_q, quo_q[31]};
    diff   = rem_sh - {1'b0, opb_q};
    if (!diff[32]) begin
      rem_n = diff[31:0];
      quo_n = {quo_q[30:0], 1'b1};
    end else begin
      rem_n = rem_sh[31:0];
      quo_n = {quo_q[30:0], 1'b0};
    end

    case (state_q)
      IDLE, FIX: begin
        state_d = IDLE;
        if (start) begin
          case (op)
            OP_MTHI: hi_d = operand_a;
            OP_MTLO: lo_d = operand_a;
            OP_MULT, OP_MULTU: begin
              if (MULT_LATENCY == 1) begin
                {hi_d, lo_d} = mul64(operand_a, operand_b, op == OP_MULT);
                done_d       = 1'b1;
              end else begin
                opa_d   = operand_a;
                opb_d   = operand_b;
                msgn_d  = (op == OP_MULT);
                cnt_d   = 6'(MULT_LATENCY - 1);
                state_d = MUL;
              end
            end
            OP_DIV, OP_DIVU: begin
              if (operand_b == 32'd0) begin
                done_d = 1'b1;
                dbz_d  = 1'b1;
              end else begin
                a_neg   = (op == OP_DIV) && operand_a[31];
                b_neg   = (op == OP_DIV) && operand_b[31];
                quo_d   = a_neg ? -operand_a : operand_a;
                opb_d   = b_neg ? -operand_b : operand_b;
                rem_d   = 32'd0;
                qneg_d  = a_neg ^ b_neg;
                rneg_d  = a_neg;
                cnt_d   = 6'd0;
                state_d = DIV;
              end
            end
            default: ;
          endcase
        end
      end
      MUL: begin
        if (cnt_q == 6'd1) begin
          {hi_d, lo_d} = mul64(opa_q, opb_q, msgn_q);
          done_d       = 1'b1;
          state_d      = IDLE;
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end
      DIV: begin
        quo_d = quo_n;
        rem_d = rem_n;
        cnt_d = cnt_q + 6'd1;
        // Last step: sign fix-up folds into the commit so results land at T+33.
        if (cnt_q == 6'd31) begin
          lo_d    = qneg_q ? -quo_n : quo_n;
          hi_d    = rneg_q ? -rem_n : rem_n;
          done_d  = 1'b1;
          state_d = FIX;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      msgn_q  <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      msgn_q  <= msgn_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy        = (state_q == MUL) || (state_q == DIV);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
endmodule

// File: tb/tb_mult_div_sequencer.sv
// Testbench for mult_div_sequencer: directed cases with literal results plus
// randomized traffic, all compared every cycle against a transaction-level model.
module tb_mult_div_sequencer;
  localparam int L = 4;
  localparam logic [5:0] MTHI = 6'b010001, MTLO = 6'b010011, MULT = 6'b011000,
                         MULTU = 6'b011001, DIV = 6'b011010, DIVU = 6'b011011;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  op = '0;
  logic [31:0] operand_a = '0, operand_b = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  mult_div_sequencer #(.MULT_LATENCY(L)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Model: an accepted op schedules its result 'rem' edges ahead.
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  logic        m_done = 1'b0, m_dbz = 1'b0;
  int          m_rem = 0;

  function automatic logic [63:0] model_mul(input logic [31:0] a, input logic [31:0] b,
                                            input bit sgn);
    longint sa, sb;
    logic [63:0] p;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      p  = 64'(sa * sb);
    end else begin
      p = {32'd0, a} * {32'd0, b};
    end
    return p;
  endfunction

  // Returns {remainder, quotient}.
  function automatic logic [63:0] model_div(input logic [31:0] a, input logic [31:0] b,
                                            input bit sgn);
    longint sa, sb, q, r;
    logic [63:0] qq, rr;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q  = sa / sb;   // truncates toward zero, remainder follows dividend
    r  = sa % sb;
    qq = 64'(q);
    rr = 64'(r);
    return {rr[31:0], qq[31:0]};
  endfunction

  always @(posedge clk) begin : model
    bit was_busy;
    logic [63:0] res;
    if (reset) begin
      m_hi = '0; m_lo = '0; m_done = 1'b0; m_dbz = 1'b0; m_rem = 0;
    end else begin
      was_busy = (m_rem > 0);
      m_done   = 1'b0;
      m_dbz    = 1'b0;
      if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) begin
          m_hi = p_hi; m_lo = p_lo; m_done = 1'b1;
        end
      end
      if (start && !was_busy) begin
        case (op)
          MTHI: m_hi = operand_a;
          MTLO: m_lo = operand_a;
          MULT, MULTU: begin
            res = model_mul(operand_a, operand_b, op == MULT);
            p_hi = res[63:32]; p_lo = res[31:0];
            if (L == 1) begin
              m_hi = p_hi; m_lo = p_lo; m_done = 1'b1;
            end else m_rem = L - 1;
          end
          DIV, DIVU: begin
            if (operand_b == 32'd0) begin
              m_done = 1'b1; m_dbz = 1'b1;
            end else begin
              res = model_div(operand_a, operand_b, op == DIV);
              p_hi = res[63:32]; p_lo = res[31:0];
              m_rem = 32;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (busy !== (m_rem > 0) || done !== m_done || div_by_zero !== m_dbz ||
          hi !== m_hi || lo !== m_lo) begin
        errors++;
        $display("FAIL cycle_cmp t=%0t got busy=%b done=%b dbz=%b hi=%h lo=%h want busy=%b done=%b dbz=%b hi=%h lo=%h",
                 $time, busy, done, div_by_zero, hi, lo, (m_rem > 0), m_done, m_dbz, m_hi, m_lo);
      end
    end
  end

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  // Called at a negedge: drives the request for this cycle, returns at the
  // next negedge (cycle T+1) with start dropped.
  task automatic issue(input logic [5:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; operand_a = a; operand_b = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits (bounded) for done; lat counts cycles from T, so T+1 means lat=1.
  task automatic wait_done(input string name, input int exp_lat);
    int lat;
    lat = 1;
    while (done !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (done !== 1'b1 || lat != exp_lat) begin
      errors++;
      $display("FAIL %s_latency got %0d (done=%b) want %0d", name, lat, done, exp_lat);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset  = 1'b0;
    chk_en = 1'b1;
    check32("reset_hi", hi, 32'h0);
    check32("reset_lo", lo, 32'h0);
    check32("reset_busy", {31'd0, busy}, 32'h0);

    issue(MULT, 32'hFFFFFFFE, 32'h3);
    check32("mult_busy_t1", {31'd0, busy}, 32'h1);
    wait_done("mult", 4);
    check32("mult_hi", hi, 32'hFFFFFFFF);
    check32("mult_lo", lo, 32'hFFFFFFFA);

    @(negedge clk);
    issue(MULTU, 32'hFFFFFFFE, 32'h3);
    check32("multu_hold_hi", hi, 32'hFFFFFFFF);
    wait_done("multu", 4);
    check32("multu_hi", hi, 32'h00000002);
    check32("multu_lo", lo, 32'hFFFFFFFA);

    @(negedge clk);
    issue(DIV, 32'hFFFFFFF9, 32'h2);
    wait_done("div_neg7", 33);
    check32("div_lo", lo, 32'hFFFFFFFD);
    check32("div_hi", hi, 32'hFFFFFFFF);
    issue(DIVU, 32'd100, 32'd7);   // back-to-back in the done cycle
    wait_done("divu_b2b", 33);
    check32("divu_lo", lo, 32'd14);
    check32("divu_hi", hi, 32'd2);

    @(negedge clk);
    issue(DIVU, 32'd100, 32'd0);
    wait_done("dbz", 1);
    check32("dbz_flag", {31'd0, div_by_zero}, 32'h1);
    check32("dbz_lo_kept", lo, 32'd14);

    @(negedge clk);
    issue(DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_done("div_ovf", 33);
    check32("div_ovf_lo", lo, 32'h80000000);
    check32("div_ovf_hi", hi, 32'h0);

    @(negedge clk);
    issue(DIV, 32'd1000, 32'd3);         // now in T+1
    repeat (9) @(negedge clk);           // now in T+10
    reset = 1'b1;
    @(negedge clk);                      // T+11
    reset = 1'b0;
    check32("rst_mid_busy", {31'd0, busy}, 32'h0);
    check32("rst_mid_lo", lo, 32'h0);
    repeat (40) begin
      @(negedge clk);
      check32("rst_no_done", {31'd0, done}, 32'h0);
    end

    issue(MTHI, 32'h12345678, 32'h0);
    check32("mthi_hi", hi, 32'h12345678);
    check32("mthi_no_done", {31'd0, done}, 32'h0);
    issue(6'b100000, 32'hDEADBEEF, 32'h1);
    check32("unlisted_busy", {31'd0, busy}, 32'h0);
    check32("unlisted_hi", hi, 32'h12345678);

    issue(MULT, 32'd5, 32'd7);
    start = 1'b1; op = MULT; operand_a = 32'd9; operand_b = 32'd9;
    repeat (3) @(negedge clk);           // held through T+1..T+3, now T+4
    start = 1'b0;
    check32("held_done", {31'd0, done}, 32'h1);
    check32("held_lo", lo, 32'd35);

    // Randomized traffic; inputs change once per cycle at the negedge.
    for (int i = 0; i < 4000; i++) begin
      logic [31:0] v [2];
      int k;
      for (int j = 0; j < 2; j++) begin
        case ($urandom_range(0, 5))
          0: v[j] = 32'h0;
          1: v[j] = 32'h80000000;
          2: v[j] = 32'hFFFFFFFF;
          3: v[j] = $urandom_range(0, 20);
          default: v[j] = $urandom;
        endcase
      end
      k = $urandom_range(0, 7);
      case (k)
        0: op = MTHI;  1: op = MTLO;  2: op = MULT;  3: op = MULTU;
        4: op = DIV;   5: op = DIVU;  6: op = 6'(($urandom_range(0, 63)));
        default: op = DIVU;
      endcase
      start     = ($urandom_range(0, 2) == 0);
      operand_a = v[0];
      operand_b = v[1];
      reset     = ($urandom_range(0, 599) == 0);
      @(negedge clk);
    end
    start = 1'b0;
    reset = 1'b0;
    repeat (40) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
